// File: rtl/mcu_timing_pkg.sv
// Tick constants, window limits and decode helpers for the 8051 machine-cycle generator.
// One machine cycle is 12 ticks: tick = 2*(state-1) + phase.
package mcu_timing_pkg;

  localparam int TICK_W = 4;
  typedef logic [TICK_W-1:0] tick_t;

  localparam tick_t TICK_S1P1 = 4'd0;
  localparam tick_t TICK_S1P2 = 4'd1;
  localparam tick_t TICK_S2P1 = 4'd2;
  localparam tick_t TICK_S2P2 = 4'd3;
  localparam tick_t TICK_S3P1 = 4'd4;
  localparam tick_t TICK_S3P2 = 4'd5;
  localparam tick_t TICK_S4P1 = 4'd6;
  localparam tick_t TICK_S4P2 = 4'd7;
  localparam tick_t TICK_S5P1 = 4'd8;
  localparam tick_t TICK_S5P2 = 4'd9;
  localparam tick_t TICK_S6P1 = 4'd10;
  localparam tick_t TICK_S6P2 = 4'd11;

  localparam tick_t ALE_W0_LO  = TICK_S1P2;
  localparam tick_t ALE_W0_HI  = TICK_S2P1;
  localparam tick_t ALE_W1_LO  = TICK_S4P2;
  localparam tick_t ALE_W1_HI  = TICK_S5P1;

  localparam tick_t PSEN_W0_LO = TICK_S2P2;
  localparam tick_t PSEN_W0_HI = TICK_S3P2;
  localparam tick_t PSEN_W1_LO = TICK_S5P2;
  localparam tick_t PSEN_W1_HI = TICK_S6P2;

  localparam logic [5:0] ST_S1 = 6'b000001;
  localparam logic [5:0] ST_S2 = 6'b000010;
  localparam logic [5:0] ST_S3 = 6'b000100;
  localparam logic [5:0] ST_S4 = 6'b001000;
  localparam logic [5:0] ST_S5 = 6'b010000;
  localparam logic [5:0] ST_S6 = 6'b100000;

  function automatic logic [5:0] tick_to_state(tick_t t);
    logic [5:0] s;
    case (t)
      TICK_S1P1, TICK_S1P2: s = ST_S1;
      TICK_S2P1, TICK_S2P2: s = ST_S2;
      TICK_S3P1, TICK_S3P2: s = ST_S3;
      TICK_S4P1, TICK_S4P2: s = ST_S4;
      TICK_S5P1, TICK_S5P2: s = ST_S5;
      TICK_S6P1, TICK_S6P2: s = ST_S6;
      default:              s = ST_S6;
    endcase
    return s;
  endfunction

  function automatic logic in_ale_window(tick_t t);
    return ((t >= ALE_W0_LO) && (t <= ALE_W0_HI)) ||
           ((t >= ALE_W1_LO) && (t <= ALE_W1_HI));
  endfunction

  function automatic logic in_psen_window(tick_t t);
    return ((t >= PSEN_W0_LO) && (t <= PSEN_W0_HI)) ||
           ((t >= PSEN_W1_LO) && (t <= PSEN_W1_HI));
  endfunction

endpackage

// File: rtl/mcu_timing_gen_if.sv
// Control and strobe bundle between the machine-cycle generator and the sequencer / bus interface.
interface mcu_timing_gen_if #(
  parameter int MC_CNT_W = 2
);
  logic                stall;
  logic [MC_CNT_W-1:0] instr_cycles;
  logic                code_fetch;

  logic [5:0]          state;
  logic                phase;
  logic                mc_start;
  logic                mc_end;
  logic [MC_CNT_W-1:0] mc_index;
  logic                instr_start;
  logic                instr_end;
  logic                ale;
  logic                psen_n;

  modport master (
    output stall, instr_cycles, code_fetch,
    input  state, phase, mc_start, mc_end, mc_index,
           instr_start, instr_end, ale, psen_n
  );

  modport slave (
    input  stall, instr_cycles, code_fetch,
    output state, phase, mc_start, mc_end, mc_index,
           instr_start, instr_end, ale, psen_n
  );
endinterface

// File: rtl/mcu_timing_gen.sv
// 8051 machine-cycle timing generator: slices clk_in into S1P1..S6P2 and frames multi-cycle instructions.
// Every output is registered and decoded from the tick value being entered on that edge.
module mcu_timing_gen
  import mcu_timing_pkg::*;
#(
  parameter int TICKS_PER_MC = 12,
  parameter int MC_CNT_W     = 2
) (
  input  logic           clk_in,
  input  logic           rst_n,
  mcu_timing_gen_if.slave bus
);

  // tick | meaning
  // 0..10 | S1P1..S6P1, free-running
  // 11    | S6P2, the only tick where stall can hold the cycle
  localparam tick_t TICK_LAST = tick_t'(TICKS_PER_MC - 1);

  tick_t               tick_q, tick_d;
  logic [MC_CNT_W-1:0] mc_index_q, mc_index_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic                cf_q, cf_d;
  logic                first_q;

  logic [5:0]          state_q;
  logic                phase_q;
  logic                mc_start_q, mc_end_q;
  logic                instr_start_q, instr_end_q;
  logic                ale_q, psen_n_q;

  logic                hold, wrap, last_mc;

  assign hold    = (tick_q == TICK_LAST) &&  bus.stall;
  assign wrap    = (tick_q == TICK_LAST) && !bus.stall;
  assign last_mc = first_q || (mc_index_q == cnt_q);

  always_comb begin
    tick_d     = tick_q;
    mc_index_d = mc_index_q;
    cnt_d      = cnt_q;
    cf_d       = cf_q;
    if (wrap) begin
      tick_d = '0;
      cf_d   = bus.code_fetch;
      if (last_mc) begin
        mc_index_d = '0;
        cnt_d      = bus.instr_cycles;
      end else begin
        mc_index_d = mc_index_q + MC_CNT_W'(1);
      end
    end else if (!hold) begin
      tick_d = tick_q + tick_t'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_q        <= TICK_LAST;
      mc_index_q    <= '0;
      cnt_q         <= '0;
      cf_q          <= 1'b0;
      first_q       <= 1'b1;
      state_q       <= ST_S6;
      phase_q       <= 1'b1;
      mc_start_q    <= 1'b0;
      mc_end_q      <= 1'b0;
      instr_start_q <= 1'b0;
      instr_end_q   <= 1'b0;
      ale_q         <= 1'b0;
      psen_n_q      <= 1'b1;
    end else begin
      tick_q        <= tick_d;
      mc_index_q    <= mc_index_d;
      cnt_q         <= cnt_d;
      cf_q          <= cf_d;
      first_q       <= first_q && !wrap;
      state_q       <= tick_to_state(tick_d);
      phase_q       <= tick_d[0];
      mc_start_q    <= wrap;
      instr_start_q <= wrap && last_mc;
      // mc_end marks entry into S6P2 only, so a held S6P2 drops it
      mc_end_q      <= !hold && (tick_d == TICK_LAST);
      instr_end_q   <= !hold && (tick_d == TICK_LAST) && (mc_index_d == cnt_d);
      ale_q         <= in_ale_window(tick_d);
      psen_n_q      <= !(cf_d && in_psen_window(tick_d));
    end
  end

  assign bus.state       = state_q;
  assign bus.phase       = phase_q;
  assign bus.mc_start    = mc_start_q;
  assign bus.mc_end      = mc_end_q;
  assign bus.mc_index    = mc_index_q;
  assign bus.instr_start = instr_start_q;
  assign bus.instr_end   = instr_end_q;
  assign bus.ale         = ale_q;
  assign bus.psen_n      = psen_n_q;

endmodule

// File: tb/tb_mcu_timing_gen.sv
// Scoreboarded bench for mcu_timing_gen: expected strobes are queued as stimulus is driven,
// then popped and compared 1 ns after the rising edge that produces them.
module tb_mcu_timing_gen;

  typedef struct packed {
    logic [5:0] state;
    logic       phase;
    logic       mc_start;
    logic       mc_end;
    logic [1:0] mc_index;
    logic       instr_start;
    logic       instr_end;
    logic       ale;
    logic       psen_n;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  mcu_timing_gen_if #(.MC_CNT_W(2)) bus ();

  mcu_timing_gen #(.TICKS_PER_MC(12), .MC_CNT_W(2)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  function automatic exp_t mk(int t, int idx, bit st, bit en, bit ist, bit ien, bit cf);
    exp_t e;
    e.state       = 6'(1 << (t / 2));
    e.phase       = (t % 2) == 1;
    e.mc_start    = st;
    e.mc_end      = en;
    e.mc_index    = 2'(idx);
    e.instr_start = ist;
    e.instr_end   = ien;
    e.ale         = (t == 1) || (t == 2) || (t == 7) || (t == 8);
    e.psen_n      = !(cf && (((t >= 3) && (t <= 5)) || ((t >= 9) && (t <= 11))));
    return e;
  endfunction

  function automatic exp_t mk_reset();
    exp_t e;
    e = '0;
    e.state  = 6'b100000;
    e.phase  = 1'b1;
    e.psen_n = 1'b1;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.state       = bus.state;
    g.phase       = bus.phase;
    g.mc_start    = bus.mc_start;
    g.mc_end      = bus.mc_end;
    g.mc_index    = bus.mc_index;
    g.instr_start = bus.instr_start;
    g.instr_end   = bus.instr_end;
    g.ale         = bus.ale;
    g.psen_n      = bus.psen_n;
    return g;
  endfunction

  task automatic tick(input bit s, input logic [1:0] ic, input bit cf);
    bus.stall        = s;
    bus.instr_cycles = ic;
    bus.code_fetch   = cf;
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst_n = 1'b0;
    exp_q.push_back(mk_reset());
    tick(0, 2'd0, 0);
    tick(0, 2'd0, 0);
    e = exp_q.pop_front();
    got = sample();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset_state got=%h expected=%h", got, e);
    end
  endtask

  task automatic test_basic();
    exp_t e, got;
    int   last_start = -1;
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      int t;
      t = c % 12;
      exp_q.push_back(mk(t, 0, t == 0, t == 11, t == 0, t == 11, 0));
      tick(0, 2'd0, 0);
      e = exp_q.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL basic cycle=%0d got=%h expected=%h", c + 1, got, e);
      end
      if (got.mc_start) begin
        if (last_start >= 0) begin
          total++;
          if (cyc - last_start != 12) begin
            bad++;
            $display("FAIL mc_period got=%0d expected=12", cyc - last_start);
          end
        end
        last_start = cyc;
      end
    end
  endtask

  task automatic test_multi_cycle();
    exp_t e, got;
    int   s_cyc = -1;
    for (int m = 0; m < 4; m++) begin
      for (int t = 0; t < 12; t++) begin
        logic [1:0] ic;
        ic = (m == 0 && t == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        exp_q.push_back(mk(t, m, t == 0, t == 11, (m == 0) && (t == 0), (m == 3) && (t == 11), 1));
        tick(0, ic, 1);
        e = exp_q.pop_front();
        got = sample();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL multi mc=%0d tick=%0d got=%h expected=%h", m, t, got, e);
        end
        if (got.instr_start) s_cyc = cyc;
        if (got.instr_end) begin
          total++;
          if (cyc - s_cyc != 47) begin
            bad++;
            $display("FAIL instr_span got=%0d expected=47", cyc - s_cyc);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e, got;
    int   end_cyc = -1;
    for (int t = 0; t < 12; t++) begin
      bit s;
      s = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      exp_q.push_back(mk(t, 0, t == 0, t == 11, t == 0, t == 11, 1));
      tick(s, 2'd0, 1);
      e = exp_q.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL stall_pre tick=%0d got=%h expected=%h", t, got, e);
      end
      if (got.mc_end) end_cyc = cyc;
    end
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(mk(11, 0, 0, 0, 0, 0, 1));
      tick(1, 2'd0, 1);
      e = exp_q.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL stall_hold k=%0d got=%h expected=%h", k, got, e);
      end
    end
    for (int t = 0; t < 12; t++) begin
      exp_q.push_back(mk(t, 0, t == 0, t == 11, t == 0, t == 11, 0));
      tick(0, 2'd0, 0);
      e = exp_q.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL stall_post tick=%0d got=%h expected=%h", t, got, e);
      end
      if (t == 0) begin
        total++;
        if ((cyc - end_cyc != 6) || !got.mc_start) begin
          bad++;
          $display("FAIL stall_gap got=%0d start=%b expected=6 start=1", cyc - end_cyc, got.mc_start);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, got;
    for (int m = 0; m < 2; m++) begin
      for (int t = 0; t < 12; t++) begin
        if (!(m == 1 && t > 6)) begin
          exp_q.push_back(mk(t, m, t == 0, t == 11, (m == 0) && (t == 0), 0, 1));
          tick(0, 2'd2, 1);
          e = exp_q.pop_front();
          got = sample();
          total++;
          if (got !== e) begin
            bad++;
            $display("FAIL pre_reset mc=%0d tick=%0d got=%h expected=%h", m, t, got, e);
          end
        end
      end
    end
    rst_n = 1'b0;
    exp_q.push_back(mk_reset());
    #1;
    e = exp_q.pop_front();
    got = sample();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL async_reset got=%h expected=%h", got, e);
    end
    exp_q.push_back(mk_reset());
    tick(0, 2'd2, 1);
    e = exp_q.pop_front();
    got = sample();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset_held got=%h expected=%h", got, e);
    end
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int t = 0; t < 12; t++) begin
        exp_q.push_back(mk(t, m, t == 0, t == 11, (m == 0) && (t == 0), (m == 1) && (t == 11), 0));
        tick(0, (m == 0 && t == 0) ? 2'd1 : 2'd3, 0);
        e = exp_q.pop_front();
        got = sample();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL post_reset mc=%0d tick=%0d got=%h expected=%h", m, t, got, e);
        end
      end
    end
  endtask

  initial begin
    bus.stall        = 1'b0;
    bus.instr_cycles = 2'd0;
    bus.code_fetch   = 1'b0;
    test_reset();
    test_basic();
    test_multi_cycle();
    test_stall();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mcu_timing_gen.md
# mcu_timing_gen

Machine-cycle timing generator for the 8051 core. Sits directly downstream of the clock divider: it consumes the divided oscillator clock and slices it into the classic 12-tick machine cycle (S1P1…S6P2). It drives one-hot state/phase strobes, ALE and PSEN_n windows, machine-cycle boundary pulses, and multi-cycle instruction framing for the sequencer and bus interface.

## Interface
Parameters:
- `TICKS_PER_MC`, 12, oscillator ticks per machine cycle (6 states × 2 phases); fixed, exposed for checking only
- `MC_CNT_W`, 2, width of the instruction machine-cycle count (max 4 cycles)

Ports:
- `clk_in`  in  1  divided oscillator clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold at S6P2; do not start the next machine cycle
- `instr_cycles`  in  MC_CNT_W  machine cycles minus 1 for the next instruction
- `code_fetch`  in  1  next machine cycle performs code fetches (enables PSEN_n)
- `state`  out  6  one-hot S1..S6 (bit0 = S1)
- `phase`  out  1  0 = P1, 1 = P2
- `mc_start`  out  1  one-cycle pulse at S1P1
- `mc_end`  out  1  one-cycle pulse on entry to S6P2
- `mc_index`  out  MC_CNT_W  machine cycle number within current instruction
- `instr_start`  out  1  mc_start of machine cycle 0
- `instr_end`  out  1  mc_end of the last machine cycle
- `ale`  out  1  address latch enable
- `psen_n`  out  1  program store enable, active low

## Operation
- Internal tick counter `tick` 0..11; tick = 2·(state−1) + phase. All outputs registered, decoded from next-tick value.
- Reset values: tick = 11 (S6P2), `state` = 6'b100000, `phase` = 1, `mc_index` = 0, `mc_start`/`mc_end`/`instr_start`/`instr_end`/`ale` = 0, `psen_n` = 1. First edge after release enters tick 0 (S1P1) with `mc_start` = 1.
- Advance: tick increments each edge; 11→0 wraps only when `stall` = 0. At tick 11 with `stall` = 1, hold everything; `mc_end` is not re-pulsed.
- On wrap into tick 0: if `mc_index` == latched count (or first cycle after reset), `mc_index` ← 0, latch `instr_cycles` and assert `instr_start`; else `mc_index` increments. `code_fetch` latched on every wrap.
- `instr_end` = `mc_end` AND `mc_index` == latched count.
- `ale` = 1 at ticks 1,2 and 7,8 (S1P2–S2P1, S4P2–S5P1).
- `psen_n` = 0 at ticks 3–5 and 9–11 when latched `code_fetch` = 1; else 1. Held level during stall at tick 11 is retained.
- `instr_cycles` and `code_fetch` ignored except at wrap edge.
- Asynchronous reset mid-cycle: all outputs return to reset values immediately; no partial pulses after release.

## Timing
- Machine cycle = 12 `clk_in` cycles when unstalled; stall adds exactly N cycles for N consecutive stalled tick-11 cycles.
- `mc_start` to `mc_end`: 11 cycles. `mc_end` to next `mc_start`: 1 cycle + stall cycles.
- Instruction of `instr_cycles` = k spans 12·(k+1) unstalled cycles; `instr_start` to `instr_end` = 12·(k+1) − 1.
- `stall` sampled each edge at tick 11; deassertion takes effect on the next edge.

## Structure
- Package `mcu_timing_pkg`: tick constants (`TICK_S1P1`=0 … `TICK_S6P2`=11), ALE window ticks, PSEN window ticks, one-hot state encodings.
- Single flat module; no sub-module needed. Tick-to-state decode as a package function.

## Test plan
- Reset release, `stall`=0, `instr_cycles`=0: `mc_start` at cycle 1, `mc_end` at cycle 12, period 12; `state` walks 1,1,2,2,…,32,32.
- `instr_cycles`=3 → `mc_index` 0,1,2,3; `instr_start` once, `instr_end` 47 cycles later; `instr_cycles` change mid-instruction ignored.
- `stall`=1 for 5 cycles at S6P2: tick held, `mc_end` single pulse, next `mc_start` 6 cycles after `mc_end`.
- `code_fetch`=1: `psen_n` low ticks 3–5, 9–11; `ale` high ticks 1,2,7,8; with `code_fetch`=0 `psen_n` stays 1.
- Assert `rst_n`=0 at tick 6 of cycle 2: outputs immediately at reset values; after release, `mc_index`=0 and `instr_start` on first `mc_start`.
